kypd_emulator: RTL and testbench

- Synthesizable keypad responder: the far end of the 4x4 PmodKYPD column-scan interface.
- Accepts key-press requests (4-bit key code) over a valid/ready handshake and holds the key down for a fixed time, then releases it.
- While a key is held, watches the active-low Col strobes from the scanner and drives the matching active-low Row line.
- Used for hardware-in-loop stimulus of the keypad decoder (Connect4 move/pop entry) without a physical keypad.

---
 rtl/kypd_pkg.sv | 49 ++++
 rtl/kypd_col_sync.sv | 25 ++
 rtl/kypd_emulator.sv | 108 ++++++++++
 tb/tb_kypd_emulator.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/kypd_pkg.sv
// rtl/kypd_pkg.sv - shared keypad patterns, state type and key map helpers
package kypd_pkg;

   // Active-low one-hot column strobes driven by the scanner
   localparam logic [3:0] COL_C0 = 4'b0111;
   localparam logic [3:0] COL_C1 = 4'b1011;
   localparam logic [3:0] COL_C2 = 4'b1101;
   localparam logic [3:0] COL_C3 = 4'b1110;

   // Active-low one-hot row lines returned to the scanner
   localparam logic [3:0] ROW_R0 = 4'b0111;
   localparam logic [3:0] ROW_R1 = 4'b1011;
   localparam logic [3:0] ROW_R2 = 4'b1101;
   localparam logic [3:0] ROW_R3 = 4'b1110;

   // No row pulled low
   localparam logic [3:0] ROW_IDLE = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESS   = 2'd1,
      ST_RELEASE = 2'd2
   } kypd_state_t;

   // Column strobe under which a key is visible
   function automatic logic [3:0] key_to_col(input logic [3:0] code);
      logic [3:0] col;
      case (code)
         4'h1, 4'h4, 4'h7, 4'h0: col = COL_C0;
         4'h2, 4'h5, 4'h8, 4'hF: col = COL_C1;
         4'h3, 4'h6, 4'h9, 4'hE: col = COL_C2;
         default:                col = COL_C3;
      endcase
      return col;
   endfunction

   // Row line a key pulls low when its column is strobed
   function automatic logic [3:0] key_to_row(input logic [3:0] code);
      logic [3:0] row;
      case (code)
         4'h1, 4'h2, 4'h3, 4'hA: row = ROW_R0;
         4'h4, 4'h5, 4'h6, 4'hB: row = ROW_R1;
         4'h7, 4'h8, 4'h9, 4'hC: row = ROW_R2;
         default:                row = ROW_R3;
      endcase
      return row;
   endfunction

endpackage

// File: rtl/kypd_col_sync.sv
// rtl/kypd_col_sync.sv - 2-flop synchronizer for the scanner column strobes
module kypd_col_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] i_col,
   output logic [3:0] o_col_sync
);

   logic [3:0] r_meta;
   logic [3:0] r_sync;

   // Two-stage capture; reset to "no column strobed"
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 4'b1111;
         r_sync <= 4'b1111;
      end else begin
         r_meta <= i_col;
         r_sync <= r_meta;
      end
   end

   assign o_col_sync = r_sync;

endmodule

// File: rtl/kypd_emulator.sv
// rtl/kypd_emulator.sv - PmodKYPD far-end responder: holds a requested key for a fixed time
module kypd_emulator
   import kypd_pkg::*;
#(
   parameter int HOLD_CYCLES = 400000,
   parameter int GAP_CYCLES  = 400000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic       key_abort,
   input  logic [3:0] Col,
   output logic [3:0] Row,
   output logic       key_active,
   output logic       busy
);

   localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

   kypd_state_t      r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_code;
   logic             r_key_ready;
   logic             r_key_active;
   logic             r_busy;
   logic [3:0]       r_row;
   logic [3:0]       w_col_sync;
   logic             w_col_match;

   kypd_col_sync u_col_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_col      (Col),
      .o_col_sync (w_col_sync)
   );

   // Key is only visible while pressed and its own column is strobed alone
   assign w_col_match = (r_state == ST_PRESS) && (w_col_sync == key_to_col(r_code));

   // Press/release sequencer; outputs registered alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_code       <= '0;
         r_key_ready  <= 1'b1;
         r_key_active <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (key_valid && r_key_ready) begin
                  r_code       <= key_code;
                  r_cnt        <= HOLD_LOAD;
                  r_state      <= ST_PRESS;
                  r_key_ready  <= 1'b0;
                  r_key_active <= 1'b1;
                  r_busy       <= 1'b1;
               end
            end
            ST_PRESS: begin
               if ((r_cnt == '0) || key_abort) begin
                  r_cnt        <= GAP_LOAD;
                  r_state      <= ST_RELEASE;
                  r_key_active <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_RELEASE: begin
               if (r_cnt == '0) begin
                  r_state     <= ST_IDLE;
                  r_key_ready <= 1'b1;
                  r_busy      <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_key_ready  <= 1'b1;
               r_key_active <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   // Registered row drive; third edge after a Col change lands here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row <= ROW_IDLE;
      end else begin
         r_row <= w_col_match ? key_to_row(r_code) : ROW_IDLE;
      end
   end

   assign Row        = r_row;
   assign key_ready  = r_key_ready;
   assign key_active = r_key_active;
   assign busy       = r_busy;

endmodule

// File: tb/tb_kypd_emulator.sv
// tb/tb_kypd_emulator.sv - directed bench for kypd_emulator
module tb_kypd_emulator;

   logic       clk;
   logic       rst_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;
   logic       key_abort;
   logic [3:0] Col;
   logic [3:0] Row;
   logic       key_active;
   logic       busy;

   int n_total;
   int n_bad;

   logic [3:0] pat [4];

   kypd_emulator #(
      .HOLD_CYCLES (20),
      .GAP_CYCLES  (10)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_abort  (key_abort),
      .Col        (Col),
      .Row        (Row),
      .key_active (key_active),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] code);
      key_code  = code;
      key_valid = 1'b1;
      tick(1);
      key_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         if (key_ready) break;
         tick(1);
      end
      chk("idle_wait", key_ready, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_total   = 0;
      n_bad     = 0;
      pat[0]    = 4'b0111;
      pat[1]    = 4'b1011;
      pat[2]    = 4'b1101;
      pat[3]    = 4'b1110;
      rst_n     = 1'b0;
      key_code  = 4'h0;
      key_valid = 1'b0;
      key_abort = 1'b0;
      Col       = 4'b1111;

      // reset state
      #22;
      chk("rst_row", Row, 4'b1111);
      chk("rst_ready", key_ready, 1'b1);
      chk("rst_active", key_active, 1'b0);
      chk("rst_busy", busy, 1'b0);
      tick(1);
      rst_n = 1'b1;
      tick(2);

      // key 5: column c1, row r1
      press(4'h5);
      chk("k5_active", key_active, 1'b1);
      chk("k5_busy", busy, 1'b1);
      chk("k5_ready", key_ready, 1'b0);
      Col = 4'b1011;
      tick(2);
      chk("k5_row_e2", Row, 4'b1111);
      tick(1);
      chk("k5_row_e3", Row, 4'b1011);
      Col = 4'b0111;
      tick(2);
      chk("k5_row_off_e2", Row, 4'b1011);
      tick(1);
      chk("k5_row_off_e3", Row, 4'b1111);
      tick(13);
      chk("k5_active_19", key_active, 1'b1);
      tick(1);
      chk("k5_active_20", key_active, 1'b0);
      chk("k5_busy_20", busy, 1'b1);
      tick(9);
      chk("k5_busy_29", busy, 1'b1);
      tick(1);
      chk("k5_busy_30", busy, 1'b0);
      chk("k5_ready_30", key_ready, 1'b1);
      Col = 4'b1111;
      wait_idle();

      // key A: column c3, row r0, with Col scanned every 4 cycles
      Col = 4'b0111;
      tick(3);
      press(4'hA);
      for (int k = 0; k < 16; k++) begin
         int         idx;
         logic [3:0] c;
         Col = pat[k / 4];
         tick(1);
         idx = k - 2;
         c   = (idx < 0) ? 4'b0111 : pat[idx / 4];
         chk($sformatf("kA_scan_%0d", k), Row, (c == 4'b1110) ? 4'b0111 : 4'b1111);
      end
      Col = 4'b1111;
      wait_idle();

      // key D with abort on PRESS cycle 5
      Col = 4'b1110;
      tick(3);
      press(4'hD);
      tick(1);
      chk("kD_row", Row, 4'b1110);
      tick(3);
      chk("kD_active_4", key_active, 1'b1);
      key_abort = 1'b1;
      tick(1);
      key_abort = 1'b0;
      chk("kD_abort_active", key_active, 1'b0);
      chk("kD_abort_busy", busy, 1'b1);
      chk("kD_abort_row_same", Row, 4'b1110);
      tick(1);
      chk("kD_abort_row_next", Row, 4'b1111);
      tick(8);
      chk("kD_rel_busy", busy, 1'b1);
      chk("kD_rel_ready", key_ready, 1'b0);
      tick(1);
      chk("kD_done_busy", busy, 1'b0);
      chk("kD_done_ready", key_ready, 1'b1);
      Col = 4'b1111;
      wait_idle();

      // valid held: 7 accepted, code changed to 3 mid-press
      Col = 4'b0111;
      tick(3);
      key_code  = 4'h7;
      key_valid = 1'b1;
      tick(1);
      chk("k7_active", key_active, 1'b1);
      tick(2);
      key_code = 4'h3;
      tick(1);
      chk("k7_row", Row, 4'b1101);
      tick(7);
      chk("k7_row_after_change", Row, 4'b1101);
      chk("k7_still_busy", busy, 1'b1);
      tick(19);
      chk("k7_ready_29", key_ready, 1'b0);
      tick(1);
      chk("k3_handshake_30", key_ready & key_valid, 1'b1);
      chk("k3_busy_30", busy, 1'b0);
      Col = 4'b1101;
      tick(1);
      key_valid = 1'b0;
      chk("k3_active_31", key_active, 1'b1);
      chk("k3_ready_31", key_ready, 1'b0);
      tick(2);
      chk("k3_row", Row, 4'b0111);
      Col = 4'b1111;
      wait_idle();

      // asynchronous reset while key 0 is visible
      Col = 4'b0111;
      tick(3);
      press(4'h0);
      tick(3);
      chk("k0_row", Row, 4'b1110);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_row", Row, 4'b1111);
      chk("arst_ready", key_ready, 1'b1);
      chk("arst_busy", busy, 1'b0);
      chk("arst_active", key_active, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      Col   = 4'b1111;
      tick(2);

      // key 1 with non-one-hot Col patterns
      Col = 4'b0011;
      tick(3);
      press(4'h1);
      for (int k = 0; k < 6; k++) begin
         tick(1);
         chk($sformatf("k1_col0011_%0d", k), Row, 4'b1111);
      end
      Col = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         tick(1);
         chk($sformatf("k1_col1111_%0d", k), Row, 4'b1111);
      end
      Col = 4'b0111;
      tick(3);
      chk("k1_row_valid_col", Row, 4'b0111);
      Col = 4'b1111;
      wait_idle();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
